// File: rtl/na_current_sequencer.sv
// na_current_sequencer
// Computes the Hodgkin-Huxley sodium current I_NA = G_NA * m^3 * h * (V - E_NA)
// over five cycles. One shared signed 16x16 multiplier performs one multiply per cycle.
// Every intermediate value is Q8.8 and the final result is Q12.4.
// Any stage that clamps to the 16-bit range raises sat for that result.
module na_current_sequencer #(
    parameter logic signed [15:0] G_NA = 16'sd30720,  // 120.0 in Q8.8
    parameter logic signed [15:0] E_NA = 16'sd12800   // 50.0 mV in Q8.8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [15:0] V,
    input  logic signed [15:0] m,
    input  logic signed [15:0] h,
    output logic signed [15:0] I_NA,
    output logic               valid,
    output logic               busy,
    output logic               sat,
    output logic               overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_M2,
        S_M3,
        S_H,
        S_G,
        S_V
    } state_t;

    // Clamped value and a flag that says whether clamping happened
    typedef struct packed {
        logic               hit;
        logic signed [15:0] val;
    } sat_t;

    // Clamp a signed 32-bit quantity into the signed 16-bit range
    function automatic sat_t sat16(input logic signed [31:0] x);
        sat_t r;
        r.hit = 1'b0;
        r.val = x[15:0];
        if (x > 32'sd32767) begin
            r.hit = 1'b1;
            r.val = 16'sh7FFF;
        end else if (x < -32'sd32768) begin
            r.hit = 1'b1;
            r.val = 16'sh8000;
        end
        return r;
    endfunction

    state_t state, state_nx;

    logic signed [15:0] m_q, h_q, diff_q, p_q;
    logic               sat_acc;

    logic signed [15:0] op_a, op_b;
    logic signed [31:0] prod;
    logic signed [16:0] diff17;
    logic signed [31:0] diff_ext;
    sat_t               diff_s, stage_s, final_s;

    // Next-state sequencing and operand selection for the shared multiplier
    always_comb begin
        // NOTE: defaults come first so every path assigns every output and no latch is inferred.
        state_nx = state;
        op_a     = p_q;
        op_b     = m_q;
        case (state)
            S_IDLE: if (start) state_nx = S_M2;
            S_M2: begin
                op_a     = m_q;
                op_b     = m_q;
                state_nx = S_M3;
            end
            S_M3: begin
                op_b     = m_q;
                state_nx = S_H;
            end
            S_H: begin
                op_b     = h_q;
                state_nx = S_G;
            end
            S_G: begin
                op_b     = G_NA;
                state_nx = S_V;
            end
            S_V: begin
                op_b     = diff_q;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Shared multiplier, reversal offset and the two scaling paths
    always_comb begin
        prod     = 32'(op_a) * 32'(op_b);
        diff17   = {V[15], V} - {E_NA[15], E_NA};
        diff_ext = 32'(diff17);
        diff_s   = sat16(diff_ext);
        stage_s  = sat16(prod >>> 8);   // Q8.8 * Q8.8 -> Q8.8
        final_s  = sat16(prod >>> 12);  // Q8.8 * Q8.8 -> Q12.4
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Operand latches, running product, result and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q     <= '0;
            h_q     <= '0;
            diff_q  <= '0;
            p_q     <= '0;
            sat_acc <= 1'b0;
            I_NA    <= '0;
            sat     <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            valid   <= (state == S_V);
            // busy is taken from the state register one cycle late, so it also covers the result cycle.
            busy    <= (state != S_IDLE);
            overrun <= overrun | (start && (state != S_IDLE));
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_q     <= m;
                        h_q     <= h;
                        diff_q  <= diff_s.val;
                        sat_acc <= diff_s.hit;
                    end
                end
                S_M2, S_M3, S_H, S_G: begin
                    p_q     <= stage_s.val;
                    sat_acc <= sat_acc | stage_s.hit;
                end
                S_V: begin
                    I_NA <= final_s.val;
                    sat  <= sat_acc | final_s.hit;
                end
                default: ;
            endcase
        end
    end

endmodule
